// File: rtl/alu_sout_deserializer_if.sv
// Receive-side bus of the ALU serial deserializer: serial line in, decoded packets out.
// master = deserializer side, slave = serial source and packet consumer.
interface alu_sout_deserializer_if;
  logic        sout;
  logic        res_valid;
  logic [31:0] res_c;
  logic [3:0]  res_flags;
  logic [2:0]  res_crc;
  logic        crc_ok;
  logic        err_valid;
  logic [2:0]  err_flags;
  logic        parity_ok;
  logic        proto_err;

  modport master (
    input  sout,
    output res_valid, res_c, res_flags, res_crc, crc_ok,
    output err_valid, err_flags, parity_ok, proto_err
  );

  modport slave (
    output sout,
    input  res_valid, res_c, res_flags, res_crc, crc_ok,
    input  err_valid, err_flags, parity_ok, proto_err
  );
endinterface

// File: rtl/alu_sout_deserializer.sv
// Samples the ALU serial line, reassembles 11-bit frames into result/error packets and
// checks framing, ordering, timeout, CRC3 and error-frame parity.
module alu_sout_deserializer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                     clk,
  input logic                     rst,
  alu_sout_deserializer_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck, StResync} state_e;

  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      frame_q, frame_d;
  logic [2:0]      data_cnt_q, data_cnt_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic [31:0]     c_q, c_d;

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_c_q, res_c_d;
  logic [3:0]  res_flags_q, res_flags_d;
  logic [2:0]  res_crc_q, res_crc_d;
  logic        crc_ok_q, crc_ok_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_flags_q, err_flags_d;
  logic        parity_ok_q, parity_ok_d;
  logic        proto_err_q, proto_err_d;

  // Frame register after 10 shifts: {type, payload[7:0], stop}.
  logic            f_type;
  logic [7:0]      payload;
  logic            stop_bit;
  logic [2:0]      crc_calc;
  logic [CntW-1:0] idle_inc;
  logic            timeout_hit;

  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  assign f_type      = frame_q[9];
  assign payload     = frame_q[8:1];
  assign stop_bit    = frame_q[0];
  assign crc_calc    = crc3({c_q, 1'b0, payload[6:3]});
  assign idle_inc    = idle_cnt_q + CntW'(1);
  assign timeout_hit = (state_q == StIdle) && (data_cnt_q != 3'd0) &&
                       (idle_inc == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!bus.sout) state_d = StShift;
      StShift:  if (bit_cnt_q == 4'd10) state_d = StCheck;
      StCheck:  state_d = stop_bit ? StIdle : StResync;
      StResync: if (bus.sout) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    data_cnt_d  = data_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    c_d         = c_q;
    res_valid_d = 1'b0;
    res_c_d     = res_c_q;
    res_flags_d = res_flags_q;
    res_crc_d   = res_crc_q;
    crc_ok_d    = crc_ok_q;
    err_valid_d = 1'b0;
    err_flags_d = err_flags_q;
    parity_ok_d = parity_ok_q;
    proto_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_cnt_q != 3'd0) idle_cnt_d = idle_inc;
        // Expiry wins over a coincident start bit; that frame opens a fresh packet.
        if (timeout_hit) begin
          proto_err_d = 1'b1;
          data_cnt_d  = 3'd0;
          idle_cnt_d  = '0;
        end
        if (!bus.sout) begin
          bit_cnt_d  = 4'd1;
          idle_cnt_d = '0;
        end
      end
      StShift: begin
        frame_d   = {frame_q[8:0], bus.sout};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      StCheck: begin
        if (!stop_bit) begin
          proto_err_d = 1'b1;
          data_cnt_d  = 3'd0;
        end else if (!f_type) begin
          if (data_cnt_q < 3'd4) begin
            case (data_cnt_q)
              3'd0:    c_d[31:24] = payload;
              3'd1:    c_d[23:16] = payload;
              3'd2:    c_d[15:8]  = payload;
              default: c_d[7:0]   = payload;
            endcase
            data_cnt_d = data_cnt_q + 3'd1;
          end else begin
            proto_err_d = 1'b1;
            data_cnt_d  = 3'd0;
          end
        end else if (!payload[7]) begin
          if (data_cnt_q == 3'd4) begin
            res_valid_d = 1'b1;
            res_c_d     = c_q;
            res_flags_d = payload[6:3];
            res_crc_d   = payload[2:0];
            crc_ok_d    = (payload[2:0] == crc_calc);
          end else begin
            proto_err_d = 1'b1;
          end
          data_cnt_d = 3'd0;
        end else if (data_cnt_q == 3'd0) begin
          err_valid_d = 1'b1;
          err_flags_d = payload[6:4];
          parity_ok_d = (payload[0] == ^payload[7:1]) && (payload[6:4] == payload[3:1]);
        end else begin
          proto_err_d = 1'b1;
          data_cnt_d  = 3'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      data_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      c_q         <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      res_flags_q <= '0;
      res_crc_q   <= '0;
      crc_ok_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_flags_q <= '0;
      parity_ok_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      data_cnt_q  <= data_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      res_flags_q <= res_flags_d;
      res_crc_q   <= res_crc_d;
      crc_ok_q    <= crc_ok_d;
      err_valid_q <= err_valid_d;
      err_flags_q <= err_flags_d;
      parity_ok_q <= parity_ok_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_c     = res_c_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_crc   = res_crc_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_flags = err_flags_q;
  assign bus.parity_ok = parity_ok_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_alu_sout_deserializer.sv
// Scoreboard bench: a packet-level model predicts every decoded event and its cycle,
// a negedge monitor pops and compares whenever the deserializer pulses.
module tb_alu_sout_deserializer;

  localparam int unsigned TO = 64;
  localparam int KRes = 0;
  localparam int KErr = 1;
  localparam int KPro = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        crc_ok;
    logic [2:0]  ef;
    logic        pok;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sout_deserializer_if bus ();
  alu_sout_deserializer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  logic [7:0] pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC3 as the remainder of {msg, 000} divided by x^3+x+1.
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] m;
    m = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    return m[2:0];
  endfunction

  task automatic push_ev(input int kind, input int at, input logic [31:0] c, input logic [3:0] f,
                         input logic [2:0] crc, input logic ok, input logic [2:0] ef,
                         input logic pok);
    ev_t e;
    e.kind = kind; e.cyc = at; e.c = c; e.flags = f; e.crc = crc;
    e.crc_ok = ok; e.ef = ef; e.pok = pok;
    exp_q.push_back(e);
  endtask

  // Packet-level rules applied to one complete frame; k = cycle its start bit was driven.
  task automatic model_frame(input logic typ, input logic [7:0] pl, input logic stop, input int k);
    logic [31:0] c;
    if (!stop) begin
      push_ev(KPro, k + 12, '0, '0, '0, 1'b0, '0, 1'b0);
      pend.delete();
    end else if (!typ) begin
      if (pend.size() < 4) pend.push_back(pl);
      else begin
        push_ev(KPro, k + 12, '0, '0, '0, 1'b0, '0, 1'b0);
        pend.delete();
      end
    end else if (!pl[7]) begin
      if (pend.size() == 4) begin
        c = {pend[0], pend[1], pend[2], pend[3]};
        push_ev(KRes, k + 12, c, pl[6:3], pl[2:0], pl[2:0] == ref_crc(c, pl[6:3]), '0, 1'b0);
      end else push_ev(KPro, k + 12, '0, '0, '0, 1'b0, '0, 1'b0);
      pend.delete();
    end else if (pend.size() == 0) begin
      push_ev(KErr, k + 12, '0, '0, '0, 1'b0, pl[6:4],
              (pl[0] == ^pl[7:1]) && (pl[6:4] == pl[3:1]));
    end else begin
      push_ev(KPro, k + 12, '0, '0, '0, 1'b0, '0, 1'b0);
      pend.delete();
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop,
                            input int gap, output int k);
    logic [10:0] bits;
    bits = {1'b0, typ, pl, stop};
    k = 0;
    for (int i = 10; i >= 0; i--) begin
      @(posedge clk); #1;
      bus.sout = bits[i];
      if (i == 10) begin
        k = cyc;
        model_frame(typ, pl, stop, k);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      bus.sout = 1'b1;
    end
  endtask

  task automatic send_result(input logic [31:0] c, input logic [3:0] f, input logic bad_crc);
    int k;
    logic [2:0] crc;
    for (int b = 3; b >= 0; b--) send_frame(1'b0, c[8*b +: 8], 1'b1, $urandom_range(1, 4), k);
    crc = ref_crc(c, f) ^ {2'b00, bad_crc};
    send_frame(1'b1, {1'b0, f, crc}, 1'b1, $urandom_range(1, 4), k);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pulses"}, {bus.res_valid, bus.err_valid, bus.proto_err}, 0);
    chk({tag, " res_c"}, bus.res_c, 0);
    chk({tag, " flags/crc/ok"}, {bus.res_flags, bus.res_crc, bus.crc_ok}, 0);
    chk({tag, " err_flags/parity_ok"}, {bus.err_flags, bus.parity_ok}, 0);
  endtask

  // Monitor
  ev_t e;
  int  npulse;
  int  akind;
  always @(negedge clk) begin
    if (!rst) begin
      npulse = int'(bus.res_valid) + int'(bus.err_valid) + int'(bus.proto_err);
      if (npulse != 0) begin
        chk("pulse one-hot", npulse, 1);
        akind = bus.res_valid ? KRes : (bus.err_valid ? KErr : KPro);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected event: got kind %0d at cycle %0d, expected none", akind, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event kind", akind, e.kind);
          chk("event cycle", cyc, e.cyc);
          if (e.kind == KRes) begin
            chk("res_c", bus.res_c, e.c);
            chk("res_flags", 32'(bus.res_flags), 32'(e.flags));
            chk("res_crc", 32'(bus.res_crc), 32'(e.crc));
            chk("crc_ok", 32'(bus.crc_ok), 32'(e.crc_ok));
          end else if (e.kind == KErr) begin
            chk("err_flags", 32'(bus.err_flags), 32'(e.ef));
            chk("parity_ok", 32'(bus.parity_ok), 32'(e.pok));
          end
        end
      end
    end
  end

  int k;
  initial begin
    logic [7:0] pl;
    logic [2:0] ef;
    int r;
    int n;
    bus.sout = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 1, 2: nominal result and corrupted CRC
    send_result(32'hDEADBEEF, 4'b1001, 1'b0);
    send_result(32'hDEADBEEF, 4'b1001, 1'b1);
    // 3: error frames with good and bad parity
    send_frame(1'b1, 8'h93, 1'b1, 2, k);
    send_frame(1'b1, 8'h92, 1'b1, 2, k);
    // 4: short packet, then a good one
    send_frame(1'b0, 8'h11, 1'b1, 1, k);
    send_frame(1'b0, 8'h22, 1'b1, 1, k);
    send_frame(1'b1, {1'b0, 4'h3, 3'h5}, 1'b1, 2, k);
    send_result(32'h0123_4567, 4'b0110, 1'b0);
    // 5: bad stop bit, then line held low must not start a frame
    send_frame(1'b0, 8'h5A, 1'b0, 0, k);
    repeat (20) begin @(posedge clk); #1; bus.sout = 1'b0; end
    repeat (2) begin @(posedge clk); #1; bus.sout = 1'b1; end
    send_result(32'hCAFE_F00D, 4'b0001, 1'b0);
    // 6: timeout after three data frames
    send_frame(1'b0, 8'hA1, 1'b1, 2, k);
    send_frame(1'b0, 8'hA2, 1'b1, 2, k);
    send_frame(1'b0, 8'hA3, 1'b1, 1, k);
    push_ev(KPro, k + 12 + TO, '0, '0, '0, 1'b0, '0, 1'b0);
    pend.delete();
    repeat (TO + 10) begin @(posedge clk); #1; end
    // Start bit sampled on the expiry cycle: timeout first, then the frame is decoded
    send_frame(1'b0, 8'hB1, 1'b1, 1, k);
    push_ev(KPro, k + 12 + TO, '0, '0, '0, 1'b0, '0, 1'b0);
    pend.delete();
    while (cyc < k + TO + 10) begin @(posedge clk); #1; end
    send_frame(1'b1, 8'h93, 1'b1, 3, k);
    // Reset mid-frame
    send_result(32'h8000_0001, 4'b1111, 1'b0);
    @(posedge clk); #1; bus.sout = 1'b0;
    repeat (4) begin @(posedge clk); #1; bus.sout = 1'($urandom_range(0, 1)); end
    rst = 1'b1;
    bus.sout = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid-frame reset");
    rst = 1'b0;
    pend.delete();
    repeat (2) begin @(posedge clk); #1; end
    send_result(32'h7F00_FF01, 4'b0100, 1'b0);

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 4);
      if (r <= 1) begin
        send_result($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      end else if (r == 2) begin
        ef = 3'($urandom_range(0, 7));
        pl = {1'b1, ef, ef, 1'b0};
        pl[0] = ^pl[7:1];
        if ($urandom_range(0, 1) == 1) pl = pl ^ (8'd1 << $urandom_range(0, 3));
        send_frame(1'b1, pl, 1'b1, $urandom_range(1, 4), k);
      end else if (r == 3) begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++)
          send_frame(1'b0, 8'($urandom), 1'b1, $urandom_range(1, 4), k);
        send_frame(1'b1, {1'b0, 7'($urandom)}, 1'b1, $urandom_range(1, 4), k);
      end else begin
        for (int i = 0; i < 5; i++)
          send_frame(1'b0, 8'($urandom), 1'b1, $urandom_range(1, 4), k);
      end
    end

    repeat (20) @(posedge clk);
    #1;
    chk("events outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
